// File: rtl/l1i_dm_cache_if.sv
// Signal bundle between the instruction cache, the core fetch/data ports and the system bus.
// The slave side is the cache; the master side is whoever drives the core requests and the bus responses.
interface l1i_dm_cache_if #(
  parameter int ADDR_WIDTH  = 24,
  parameter int INSTR_WIDTH = 16
) ();
  // Handshake: every request (if_req, d_read, d_write) is held until its one-cycle
  // completion pulse (if_rdy / d_rdy) or error pulse (if_fault / d_fault); a bus
  // transaction is active while bus_req is high and ends on bus_done or bus_err.
  logic                   if_req;
  logic [ADDR_WIDTH-1:1]  if_addr;
  logic                   if_rdy;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic                   if_fault;
  logic                   d_read;
  logic                   d_write;
  logic [ADDR_WIDTH-1:0]  d_addr;
  logic [7:0]             d_wdata;
  logic [7:0]             d_rdata;
  logic                   d_rdy;
  logic                   d_fault;
  logic                   flush;
  logic                   flush_busy;
  logic                   bus_req;
  logic                   bus_we;
  logic                   bus_burst;
  logic [ADDR_WIDTH-1:0]  bus_addr;
  logic [7:0]             bus_wdata;
  logic [INSTR_WIDTH-1:0] bus_rdata;
  logic                   bus_beat;
  logic                   bus_done;
  logic                   bus_err;

  modport slave (
    input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, flush,
    input  bus_rdata, bus_beat, bus_done, bus_err,
    output if_rdy, if_instr, if_fault, d_rdata, d_rdy, d_fault, flush_busy,
    output bus_req, bus_we, bus_burst, bus_addr, bus_wdata
  );

  modport master (
    output if_req, if_addr, d_read, d_write, d_addr, d_wdata, flush,
    output bus_rdata, bus_beat, bus_done, bus_err,
    input  if_rdy, if_instr, if_fault, d_rdata, d_rdy, d_fault, flush_busy,
    input  bus_req, bus_we, bus_burst, bus_addr, bus_wdata
  );
endinterface

// File: rtl/l1i_dm_cache.sv
// Direct-mapped L1 instruction cache with burst line fill, uncached byte data path
// and a one-line-per-cycle invalidate-all sweep. Stores that hit a cached line invalidate it.
module l1i_dm_cache #(
  parameter int ADDR_WIDTH  = 24,
  parameter int INSTR_WIDTH = 16,
  parameter int LINE_NUM    = 8,
  parameter int LINE_WORDS  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  l1i_dm_cache_if.slave       cif,
  output logic [2:0]          dbg_state
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = ADDR_WIDTH - 1 - OFF_W - IDX_W;
  localparam logic [OFF_W:0]   CNT_FULL = (OFF_W+1)'(LINE_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FILL = 3'd1, S_DRD = 3'd2, S_DWR = 3'd3, S_FLUSH = 3'd4, S_FAULT = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [OFF_W:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]        fidx_q, fidx_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    src_data_q, src_data_d;
  logic [IDX_W-1:0]        fill_idx_q, fill_idx_d;
  logic [TAG_W-1:0]        fill_tag_q, fill_tag_d;
  logic                    bus_req_q, bus_req_d;
  logic                    bus_we_q, bus_we_d;
  logic                    bus_burst_q, bus_burst_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [7:0]              bus_wdata_q, bus_wdata_d;
  logic [7:0]              d_rdata_q, d_rdata_d;
  logic                    d_rdy_q, d_rdy_d;
  logic                    if_rdy_q;
  logic [LINE_NUM-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q [LINE_NUM];
  logic [TAG_W-1:0]        tag_d [LINE_NUM];
  logic [INSTR_WIDTH-1:0]  mem [LINE_NUM*LINE_WORDS];
  logic [INSTR_WIDTH-1:0]  rdata_q;
  logic                    ram_re, ram_we;
  logic [IDX_W+OFF_W-1:0]  ram_raddr, ram_waddr;

  logic [IDX_W-1:0] if_idx, d_idx;
  logic [TAG_W-1:0] if_tag, d_tag;
  logic [OFF_W-1:0] if_off;
  logic             if_hit;

  assign if_idx    = cif.if_addr[OFF_W+IDX_W:OFF_W+1];
  assign if_tag    = cif.if_addr[ADDR_WIDTH-1:OFF_W+IDX_W+1];
  assign if_off    = cif.if_addr[OFF_W:1];
  assign d_idx     = cif.d_addr[OFF_W+IDX_W:OFF_W+1];
  assign d_tag     = cif.d_addr[ADDR_WIDTH-1:OFF_W+IDX_W+1];
  assign if_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ram_raddr = {if_idx, if_off};
  assign ram_waddr = {fill_idx_q, cnt_q[OFF_W-1:0]};
  assign ram_we    = (state_q == S_FILL) && cif.bus_beat && !cnt_q[OFF_W];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fidx_d       = fidx_q;
    flush_pend_d = flush_pend_q | cif.flush;
    src_data_d   = src_data_q;
    fill_idx_d   = fill_idx_q;
    fill_tag_d   = fill_tag_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_burst_d  = bus_burst_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    d_rdata_d    = d_rdata_q;
    d_rdy_d      = 1'b0;
    ram_re       = 1'b0;
    valid_d      = valid_q;
    tag_d        = tag_q;
    case (state_q)
      S_IDLE: begin
        // A data request still high during its d_rdy cycle is the one just completed.
        if (flush_pend_q || cif.flush) begin
          state_d      = S_FLUSH;
          flush_pend_d = 1'b0;
          fidx_d       = '0;
        end else if ((cif.d_write || cif.d_read) && !d_rdy_q) begin
          state_d     = cif.d_write ? S_DWR : S_DRD;
          src_data_d  = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = cif.d_write;
          bus_burst_d = 1'b0;
          bus_addr_d  = cif.d_addr;
          bus_wdata_d = cif.d_wdata;
          if (cif.d_write && valid_q[d_idx] && (tag_q[d_idx] == d_tag)) valid_d[d_idx] = 1'b0;
        end else if (cif.if_req) begin
          if (if_hit) begin
            ram_re = 1'b1;
          end else begin
            state_d     = S_FILL;
            cnt_d       = '0;
            src_data_d  = 1'b0;
            fill_idx_d  = if_idx;
            fill_tag_d  = if_tag;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_burst_d = 1'b1;
            bus_addr_d  = {cif.if_addr[ADDR_WIDTH-1:OFF_W+1], {(OFF_W+1){1'b0}}};
          end
        end
      end
      S_FILL: begin
        if (ram_we) cnt_d = cnt_q + (OFF_W+1)'(1);
        if (cif.bus_err || cif.bus_done) begin
          bus_req_d   = 1'b0;
          bus_burst_d = 1'b0;
          state_d     = S_FAULT;
          if (!cif.bus_err && cnt_q == CNT_FULL) begin
            state_d               = S_IDLE;
            tag_d[fill_idx_q]     = fill_tag_q;
            valid_d[fill_idx_q]   = 1'b1;
          end
        end
      end
      S_DRD, S_DWR: begin
        if (cif.bus_err || cif.bus_done) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          state_d   = cif.bus_err ? S_FAULT : S_IDLE;
          d_rdy_d   = !cif.bus_err;
          if (!cif.bus_err && state_q == S_DRD) d_rdata_d = cif.bus_rdata[7:0];
        end
      end
      S_FLUSH: begin
        valid_d[fidx_q] = 1'b0;
        fidx_d          = fidx_q + IDX_W'(1);
        if (fidx_q == LAST_IDX) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fidx_q       <= '0;
      flush_pend_q <= 1'b0;
      src_data_q   <= 1'b0;
      fill_idx_q   <= '0;
      fill_tag_q   <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_burst_q  <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      d_rdata_q    <= '0;
      d_rdy_q      <= 1'b0;
      if_rdy_q     <= 1'b0;
      valid_q      <= '0;
      for (int i = 0; i < LINE_NUM; i++) tag_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fidx_q       <= fidx_d;
      flush_pend_q <= flush_pend_d;
      src_data_q   <= src_data_d;
      fill_idx_q   <= fill_idx_d;
      fill_tag_q   <= fill_tag_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_burst_q  <= bus_burst_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      d_rdata_q    <= d_rdata_d;
      d_rdy_q      <= d_rdy_d;
      if_rdy_q     <= ram_re;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
    end
  end

  // Data RAM: write port owned by the fill, registered read port feeds if_instr.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= cif.bus_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rdata_q <= '0;
    else if (ram_re) rdata_q <= mem[ram_raddr];
  end

  assign cif.if_rdy     = if_rdy_q;
  assign cif.if_instr   = rdata_q;
  assign cif.if_fault   = (state_q == S_FAULT) && !src_data_q;
  assign cif.d_fault    = (state_q == S_FAULT) && src_data_q;
  assign cif.d_rdata    = d_rdata_q;
  assign cif.d_rdy      = d_rdy_q;
  assign cif.flush_busy = flush_pend_q || (state_q == S_FLUSH);
  assign cif.bus_req    = bus_req_q;
  assign cif.bus_we     = bus_we_q;
  assign cif.bus_burst  = bus_burst_q;
  assign cif.bus_addr   = bus_addr_q;
  assign cif.bus_wdata  = bus_wdata_q;
  assign dbg_state      = state_q;
endmodule

// File: doc/l1i_dm_cache.md
# l1i_dm_cache

Parametrised direct-mapped L1 instruction cache with an uncached byte data path, the successor to the fixed-geometry I$ in the KC-LS1u SoC. It sits between the core's fetch and load/store ports and the system bus interface. It adds configurable line count and line length, burst line fill with a beat counter, and a multi-cycle invalidate-all sweep. Data-port writes that hit a cached line invalidate that line, which keeps self-modifying code coherent.

## Interface
- ADDR_WIDTH, 24, byte address width
- INSTR_WIDTH, 16, instruction and fill-beat width; the fetch address is halfword-granular
- LINE_NUM, 8, number of lines; power of two, ≥2
- LINE_WORDS, 64, instructions per line; power of two, ≥2
- Derived: OFF_W=clog2(LINE_WORDS), IDX_W=clog2(LINE_NUM), TAG_W=ADDR_WIDTH-1-OFF_W-IDX_W
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held until if_rdy or if_fault
- if_addr  in  ADDR_WIDTH-1  fetch address [ADDR_WIDTH-1:1]
- if_rdy  out  1  one-cycle pulse: if_instr is valid
- if_instr  out  INSTR_WIDTH  fetched instruction
- if_fault  out  1  one-cycle pulse: fill bus error
- d_read, d_write  in  1  uncached data access; held until d_rdy or d_fault; never both high
- d_addr  in  ADDR_WIDTH  data byte address
- d_wdata  in  8  store data
- d_rdata  out  8  load data, registered
- d_rdy, d_fault  out  1  one-cycle completion / error pulses
- flush  in  1  invalidate-all request pulse
- flush_busy  out  1  high while a flush is pending or sweeping
- bus_req  out  1  bus transaction active
- bus_we  out  1  write transaction
- bus_burst  out  1  line fill, LINE_WORDS beats
- bus_addr  out  ADDR_WIDTH  line base for fills (offset bits zero); d_addr for single accesses
- bus_wdata  out  8  store data
- bus_rdata  in  INSTR_WIDTH  beat / read data; byte reads use [7:0]
- bus_beat  in  1  bus_rdata valid, one fill beat
- bus_done  in  1  transaction complete
- bus_err  in  1  transaction failed; dominates bus_done

## Operation
- Storage:
  - Tag and valid arrays in flops; valid is LINE_NUM bits.
  - Data array is a synchronous 1R1W RAM of LINE_NUM*LINE_WORDS x INSTR_WIDTH.
  - Index = if_addr[OFF_W+IDX_W:OFF_W+1]; tag = upper bits.
- States: IDLE, FILL, DRD, DWR, FLUSH, FAULT.
- IDLE arbitration, highest priority first: pending flush, then d_write, then d_read, then if_req.
  - Fetch hit: RAM read issued; if_rdy the next cycle.
  - Fetch miss: go to FILL and clear the beat counter.
- FILL:
  - bus_req=1, bus_burst=1.
  - Each bus_beat writes the RAM at {idx, cnt}, then cnt++.
  - bus_done with cnt==LINE_WORDS: write tag, set valid, go to IDLE. The fetch then re-looks up and hits.
  - bus_err, or bus_done with cnt≠LINE_WORDS: go to FAULT; the line stays invalid.
  - Beats after cnt==LINE_WORDS are ignored.
- DRD: bus_req=1, bus_we=0. On bus_done, capture bus_rdata[7:0] into d_rdata, pulse d_rdy, go to IDLE.
- DWR:
  - bus_req=1, bus_we=1.
  - On entry, if d_addr's line is valid and its tag matches, clear that valid bit.
  - On bus_done, pulse d_rdy and go to IDLE.
- FLUSH: clear one valid bit per cycle, index 0..LINE_NUM-1, then go to IDLE. flush_busy drops when returning to IDLE.
- FAULT: one cycle; pulse if_fault or d_fault according to the access source; go to IDLE.
- A flush arriving in any non-IDLE state is latched as pending. A line filled before the sweep is therefore invalidated.

## Timing
- Reset:
  - State IDLE; all valid bits 0; cnt 0; pending flush 0.
  - Every output 0, including d_rdata and if_instr.
  - Reset asserted mid-transaction drops bus_req immediately and abandons the fill.
- Fetch hit latency is 1 cycle. Back-to-back hits sustain one instruction per cycle.
- Fetch miss: bus_req rises the cycle after if_req is sampled. if_rdy comes 2 cycles after the final bus_done (IDLE re-lookup, then RAM read).
- bus_req, bus_addr, bus_we and bus_burst are registered and stable until the cycle after bus_done or bus_err.
- Data access: bus_req the cycle after acceptance; d_rdy the cycle after bus_done.
- A flush takes LINE_NUM cycles in FLUSH.
- If if_req and d_* are asserted together, the fetch waits; if_rdy stays low until the data access completes.

## Test plan
- Cold fetch of 0x000100:
  - Required: burst at bus_addr 0x000100 (LINE_WORDS=64 → 128-byte line).
  - 64 beats of data i, done → if_rdy with if_instr=0x0000 exactly 2 cycles later.
  - Then fetch 0x000102 → hit, if_instr=0x0001, no bus_req.
- Fill with bus_err on beat 10 → if_fault pulse, no if_rdy. Re-fetch of the same address → new burst (line not valid).
- Store to 0x000104 while line 0x000100 is valid:
  - Required: single write, d_rdy, line invalidated.
  - Next fetch 0x000100 → new burst.
- flush asserted mid-fill (beat 30):
  - Required: the fill completes, then FLUSH for 8 cycles, flush_busy high throughout.
  - A fetch of the filled address then misses.
- d_read of 0x00ABCD with bus_rdata=0x12EF → d_rdata=0xEF; a simultaneous if_req is serviced only after d_rdy.
- Assert rst_n=0 mid-burst → bus_req and all outputs are 0 asynchronously; after release, every fetch misses.
